// File: rtl/digit_serial_adder.sv
// digit_serial_adder: adds or subtracts two WIDTH-bit operands DIGIT bits per clock
// with valid/ready handshakes, producing sum, carry-out and signed overflow.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic carry_q, cout_q, ovf_q;
  logic [NDIG-1:0][DIGIT-1:0] a_q, b_q, sum_q;
  logic [DIGIT-1:0] s_d;
  logic c_d, cm_d;
  assign {c_d, s_d} = {1'b0, a_q[cnt_q]} + {1'b0, b_q[cnt_q]} + (DIGIT+1)'(carry_q);
  // Carry into a digit's top bit falls out of that bit's sum and operand bits.
  assign cm_d = s_d[DIGIT-1] ^ a_q[cnt_q][DIGIT-1] ^ b_q[cnt_q][DIGIT-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= sub ? ~b : b;
          carry_q <= sub | cin;
          cnt_q   <= '0;
          sum_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          sum_q[cnt_q] <= s_d;
          carry_q      <= c_d;
          cnt_q        <= cnt_q + 1'b1;
          if (cnt_q == CW'(NDIG-1)) begin
            cout_q  <= c_d;
            ovf_q   <= cm_d ^ c_d;
            state_q <= DONE;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule
